pair_byte_arbiter: RTL and testbench

Round-robin arbiter that shares one 8-to-16 width packer between NUM_REQ byte-stream requesters. It grants one requester for exactly two bytes, so each packed 16-bit word never mixes sources. If the second byte stalls, it pads the word with a fixed byte. It sits directly upstream of the packer and drives the packer's valid_in/data_in; the packer has no backpressure.

---
 rtl/pair_arb_pkg.sv | 37 +++
 rtl/rr_pick_comb.sv | 34 +++
 rtl/pair_byte_arbiter.sv | 152 +++++++++++++++
 tb/tb_pair_byte_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pair_arb_pkg.sv
// Shared types and helpers for the pair-byte arbiter: FSM state encoding,
// pad counter width and the rotate-priority search used for grants.
package pair_arb_pkg;

  localparam int unsigned PAD_CNT_W = 16;
  localparam int unsigned MAX_REQ   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    PAD  = 2'd3
  } arb_state_t;

  // First set bit of valid at or after ptr, wrapping within n requesters;
  // returns ptr when nothing is valid.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [2:0]         ptr,
                                         input int unsigned        n);
    logic [2:0]  pick;
    logic        found;
    int unsigned idx;
    logic [2:0]  idx3;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx  = (32'(ptr) + k) % n;
      idx3 = 3'(idx);
      if (k < n && !found && valid[idx3]) begin
        pick  = idx3;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_pick_comb.sv
// Combinational rotate-priority encoder: picks the first valid requester
// searching upward from ptr with wrap.
module rr_pick_comb
  import pair_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned SRC_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [SRC_W-1:0]   ptr,
  output logic [SRC_W-1:0]   pick,
  output logic               any_valid
);

  logic [MAX_REQ-1:0] valid_ext;
  logic [2:0]         ptr_ext;
  logic [2:0]         pick_ext;

  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = valid;
    ptr_ext                  = '0;
    ptr_ext[SRC_W-1:0]       = ptr;
    pick_ext                 = rr_pick(valid_ext, ptr_ext, NUM_REQ);
    // Narrow by matching against each legal index so every result bit is used.
    pick = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_ext == 3'(i)) pick = SRC_W'(i);
    end
  end

  assign any_valid = |valid;

endmodule

// File: rtl/pair_byte_arbiter.sv
// Round-robin arbiter feeding an 8-to-16 packer: each grant delivers exactly
// two bytes from one requester, padding the second byte on timeout.
module pair_byte_arbiter
  import pair_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned SRC_W    = 2,
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [7:0]  PAD_BYTE = 8'h00
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arb_en,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*8-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   out_valid,
  output logic [7:0]             out_data,
  output logic [SRC_W-1:0]       out_src,
  output logic                   out_pad,
  output logic                   busy,
  output logic [PAD_CNT_W-1:0]   pad_count
);

  localparam int unsigned       TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [SRC_W-1:0]  SRC_LAST = SRC_W'(NUM_REQ - 1);

  arb_state_t           state_q, state_d;
  logic [SRC_W-1:0]     gnt_q, gnt_d;
  logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [TMR_W-1:0]     timer_q, timer_d;

  logic                 out_valid_d;
  logic [7:0]           out_data_d;
  logic [SRC_W-1:0]     out_src_d;
  logic                 out_pad_d;
  logic [PAD_CNT_W-1:0] pad_count_d;

  logic [SRC_W-1:0]     pick;
  logic                 any_valid;
  logic [NUM_REQ-1:0]   gnt_onehot;
  logic [7:0]           gnt_byte;
  logic                 accept;
  logic [SRC_W-1:0]     ptr_after;

  rr_pick_comb #(
    .NUM_REQ (NUM_REQ),
    .SRC_W   (SRC_W)
  ) u_pick (
    .valid     (req_valid),
    .ptr       (rr_ptr_q),
    .pick      (pick),
    .any_valid (any_valid)
  );

  always_comb begin
    gnt_onehot = '0;
    gnt_byte   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_q == SRC_W'(i)) begin
        gnt_onehot[i] = 1'b1;
        gnt_byte      = req_data[8*i +: 8];
      end
    end
  end

  assign req_ready = (state_q == LO || state_q == HI) ? gnt_onehot : '0;
  assign accept    = |(req_valid & req_ready);
  assign ptr_after = (gnt_q == SRC_LAST) ? '0 : gnt_q + 1'b1;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_ptr_d    = rr_ptr_q;
    timer_d     = timer_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data;
    out_src_d   = out_src;
    out_pad_d   = out_pad;
    pad_count_d = pad_count;
    case (state_q)
      IDLE: begin
        if (arb_en && any_valid) begin
          gnt_d   = pick;
          state_d = LO;
        end
      end
      LO: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = gnt_byte;
          out_src_d   = gnt_q;
          out_pad_d   = 1'b0;
          timer_d     = '0;
          state_d     = HI;
        end
      end
      HI: begin
        // An accept on the final wait cycle takes priority over padding.
        if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = gnt_byte;
          out_src_d   = gnt_q;
          out_pad_d   = 1'b0;
          rr_ptr_d    = ptr_after;
          state_d     = IDLE;
        end else if (timer_q == TMR_LAST) begin
          state_d = PAD;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      PAD: begin
        out_valid_d = 1'b1;
        out_data_d  = PAD_BYTE;
        out_src_d   = gnt_q;
        out_pad_d   = 1'b1;
        if (pad_count != '1) pad_count_d = pad_count + 1'b1;
        rr_ptr_d    = ptr_after;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      rr_ptr_q  <= '0;
      timer_q   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      out_pad   <= 1'b0;
      pad_count <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rr_ptr_q  <= rr_ptr_d;
      timer_q   <= timer_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_src   <= out_src_d;
      out_pad   <= out_pad_d;
      pad_count <= pad_count_d;
    end
  end

endmodule

// File: tb/tb_pair_byte_arbiter.sv
// Self-checking bench for pair_byte_arbiter: vector table, directed corner
// sequences and a randomized run against a deadline-based reference model.
module tb_pair_byte_arbiter;

  localparam int unsigned NUM_REQ  = 4;
  localparam int unsigned SRC_W    = 2;
  localparam int unsigned TIMEOUT  = 16;
  localparam logic [7:0]  PAD_BYTE = 8'h00;

  logic        clk = 1'b0;
  logic        rst;
  logic        arb_en;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_src;
  logic        out_pad;
  logic        busy;
  logic [15:0] pad_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pair_byte_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .SRC_W    (SRC_W),
    .TIMEOUT  (TIMEOUT),
    .PAD_BYTE (PAD_BYTE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .arb_en    (arb_en),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_pad   (out_pad),
    .busy      (busy),
    .pad_count (pad_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expire(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input string name, input int budget);
    int c;
    c = 0;
    do begin
      step();
      c++;
    end while (!out_valid && c < budget);
    if (!out_valid) expire(name);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        en;
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  rdy;
    logic        ov;
    logic [7:0]  od;
    logic [1:0]  os;
    logic        op;
    logic        bsy;
  } vec_t;

  vec_t vt[11];

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_FIRST, M_SECOND, M_FILL} mphase_t;
  mphase_t     mp;
  int          m_gnt, m_ptr, m_cyc, m_deadline, m_pads;
  logic        e_ov;
  logic [7:0]  e_od;
  int          e_os;
  logic        e_op;

  function automatic int pick_from(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (p + k) % 4;
      if (v[j]) return j;
    end
    return p;
  endfunction

  function automatic logic [3:0] model_ready();
    logic [3:0] r;
    r = '0;
    if (mp == M_FIRST || mp == M_SECOND) r[m_gnt] = 1'b1;
    return r;
  endfunction

  task automatic model_emit(input logic [7:0] b, input logic p);
    e_ov = 1'b1;
    e_od = b;
    e_os = m_gnt;
    e_op = p;
  endtask

  task automatic model_edge(input logic r, input logic en, input logic [3:0] v, input logic [31:0] d);
    m_cyc++;
    e_ov = 1'b0;
    if (r) begin
      mp = M_IDLE; m_ptr = 0; m_gnt = 0; m_pads = 0;
      e_od = 8'h00; e_os = 0; e_op = 1'b0;
    end else begin
      case (mp)
        M_IDLE: if (en && v != 4'b0) begin
          m_gnt = pick_from(v, m_ptr);
          mp    = M_FIRST;
        end
        M_FIRST: if (v[m_gnt]) begin
          model_emit(d[8*m_gnt +: 8], 1'b0);
          m_deadline = m_cyc + int'(TIMEOUT);
          mp = M_SECOND;
        end
        M_SECOND: begin
          if (v[m_gnt]) begin
            model_emit(d[8*m_gnt +: 8], 1'b0);
            m_ptr = (m_gnt + 1) % 4;
            mp    = M_IDLE;
          end else if (m_cyc == m_deadline) begin
            mp = M_FILL;
          end
        end
        M_FILL: begin
          model_emit(PAD_BYTE, 1'b1);
          if (m_pads < 65535) m_pads++;
          m_ptr = (m_gnt + 1) % 4;
          mp    = M_IDLE;
        end
      endcase
    end
  endtask

  // ---------------- stimulus state ----------------
  logic [3:0] hs;
  int         beats[4];
  int         got, n;
  logic [3:0] last_rdy;
  logic [7:0] pend[4];
  bit         hold_v[4];
  int         gap[4];
  logic [3:0] exp_rdy, acc;
  logic       r_in;
  int         fair_src[10];
  logic [7:0] fair_dat[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fair_src = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    fair_dat = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h02, 8'h03};

    //         en    valid    data           rdy      ov    od     os    op    busy
    vt[0]  = '{1'b1, 4'b0001, 32'h000000A1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1};
    vt[1]  = '{1'b1, 4'b0001, 32'h000000A1, 4'b0001, 1'b1, 8'hA1, 2'd0, 1'b0, 1'b1};
    vt[2]  = '{1'b1, 4'b0001, 32'h000000B2, 4'b0001, 1'b1, 8'hB2, 2'd0, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 4'b0000, 32'h00000000, 4'b0000, 1'b0, 8'hB2, 2'd0, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 4'b0010, 32'h0000C300, 4'b0000, 1'b0, 8'hB2, 2'd0, 1'b0, 1'b1};
    vt[5]  = '{1'b1, 4'b0010, 32'h0000C300, 4'b0010, 1'b1, 8'hC3, 2'd1, 1'b0, 1'b1};
    vt[6]  = '{1'b1, 4'b0010, 32'h0000D400, 4'b0010, 1'b1, 8'hD4, 2'd1, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 4'b0001, 32'h000000A1, 4'b0000, 1'b0, 8'hD4, 2'd1, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 4'b0001, 32'h000000A1, 4'b0000, 1'b0, 8'hD4, 2'd1, 1'b0, 1'b1};
    vt[9]  = '{1'b1, 4'b0001, 32'h000000A1, 4'b0001, 1'b1, 8'hA1, 2'd0, 1'b0, 1'b1};
    vt[10] = '{1'b1, 4'b0000, 32'h00000000, 4'b0001, 1'b0, 8'hA1, 2'd0, 1'b0, 1'b1};

    // Reset state
    rst = 1'b1; arb_en = 1'b0; req_valid = '0; req_data = '0;
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_out_pad", out_pad, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pad_count", pad_count, 0);
    chk("rst_req_ready", req_ready, 0);
    rst = 1'b0;

    // Table-driven single-requester and arb_en vectors
    for (int k = 0; k < 11; k++) begin
      arb_en = vt[k].en; req_valid = vt[k].v; req_data = vt[k].d;
      #1;
      chk($sformatf("vec%0d_ready", k), req_ready, vt[k].rdy);
      step();
      chk($sformatf("vec%0d_out_valid", k), out_valid, vt[k].ov);
      chk($sformatf("vec%0d_out_data", k), out_data, vt[k].od);
      chk($sformatf("vec%0d_out_src", k), out_src, vt[k].os);
      chk($sformatf("vec%0d_out_pad", k), out_pad, vt[k].op);
      chk($sformatf("vec%0d_busy", k), busy, vt[k].bsy);
    end

    // Reset while in HI: everything clears and the pointer returns to 0
    rst = 1'b1; arb_en = 1'b1; req_valid = 4'b1111; req_data = 32'h30201000;
    step();
    chk("hrst_out_valid", out_valid, 0);
    chk("hrst_out_data", out_data, 0);
    chk("hrst_busy", busy, 0);
    chk("hrst_req_ready", req_ready, 0);
    rst = 1'b0;
    step();
    chk("hrst_next_grant", req_ready, 4'b0001);

    // Fairness: all requesters valid, byte = 0x10*i + beat
    for (int i = 0; i < 4; i++) beats[i] = 0;
    got = 0;
    for (int c = 0; c < 60 && got < 10; c++) begin
      for (int i = 0; i < 4; i++) req_data[8*i +: 8] = 8'(16 * i + beats[i]);
      #1;
      hs = req_valid & req_ready;
      step();
      for (int i = 0; i < 4; i++) if (hs[i]) beats[i]++;
      if (out_valid) begin
        chk($sformatf("fair%0d_src", got), out_src, fair_src[got]);
        chk($sformatf("fair%0d_data", got), out_data, fair_dat[got]);
        got++;
      end
    end
    if (got < 10) expire("fair_outputs");
    req_valid = '0;

    // Timeout pad: req2 sends 0x55 then stalls; req3 waits
    req_valid = 4'b1100; req_data = 32'h77550000;
    wait_out("to_first", 10);
    chk("to_first_data", out_data, 8'h55);
    chk("to_first_src", out_src, 2);
    req_valid = 4'b1000;
    n = 0; last_rdy = 'x;
    do begin
      last_rdy = req_ready;
      step();
      n++;
    end while (!out_valid && n < 40);
    chk("to_pad_delay", n, 17);
    chk("to_pad_ready_low", last_rdy, 0);
    chk("to_pad_flag", out_pad, 1);
    chk("to_pad_data", out_data, PAD_BYTE);
    chk("to_pad_src", out_src, 2);
    chk("to_pad_count", pad_count, 1);
    wait_out("to_next", 10);
    chk("to_next_src", out_src, 3);
    chk("to_next_data", out_data, 8'h77);
    chk("to_next_pad", out_pad, 0);
    wait_out("to_next2", 10);
    chk("to_next2_src", out_src, 3);
    req_valid = '0;

    // Second byte on the final HI cycle is accepted, no pad
    req_valid = 4'b0001; req_data = 32'h0000005A;
    wait_out("last_first", 10);
    chk("last_first_data", out_data, 8'h5A);
    req_valid = '0;
    for (int c = 0; c < 15; c++) step();
    req_valid = 4'b0001; req_data = 32'h0000006B;
    step();
    chk("last_out_valid", out_valid, 1);
    chk("last_out_data", out_data, 8'h6B);
    chk("last_out_pad", out_pad, 0);
    chk("last_pad_count", pad_count, 1);
    req_valid = '0;
    step();
    chk("last_after_valid", out_valid, 0);
    chk("last_after_busy", busy, 0);

    // arb_en dropped during HI of req1
    arb_en = 1'b1; req_valid = 4'b1111; req_data = 32'h44332211;
    wait_out("en_first", 10);
    chk("en_first_src", out_src, 1);
    arb_en = 1'b0;
    step();
    chk("en_second_valid", out_valid, 1);
    chk("en_second_src", out_src, 1);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("en_hold_busy", busy, 0);
      chk("en_hold_valid", out_valid, 0);
    end
    arb_en = 1'b1;
    step();
    chk("en_regrant_busy", busy, 1);
    step();
    chk("en_regrant_src", out_src, 2);
    chk("en_regrant_data", out_data, 8'h33);
    step();
    req_valid = '0;

    // Randomized run against the reference model
    mp = M_IDLE; m_gnt = 0; m_ptr = 0; m_cyc = 0; m_deadline = 0; m_pads = 0;
    e_ov = 0; e_od = 0; e_os = 0; e_op = 0;
    for (int i = 0; i < 4; i++) begin hold_v[i] = 0; gap[i] = 0; pend[i] = 0; end
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!hold_v[i]) begin
          if (gap[i] > 0) gap[i]--;
          else if ($urandom_range(2) == 0) begin
            hold_v[i] = 1;
            pend[i]   = 8'($urandom);
          end
        end
      end
      r_in   = (c == 0) || ($urandom_range(799) == 0);
      rst    = r_in;
      arb_en = ($urandom_range(9) != 0);
      for (int i = 0; i < 4; i++) begin
        req_valid[i]       = hold_v[i];
        req_data[8*i +: 8] = pend[i];
      end
      #1;
      exp_rdy = model_ready();
      if (c > 0) chk("rand_ready", req_ready, exp_rdy);
      acc = req_valid & exp_rdy;
      model_edge(rst, arb_en, req_valid, req_data);
      step();
      chk("rand_out_valid", out_valid, e_ov);
      chk("rand_out_data", out_data, e_od);
      chk("rand_out_src", out_src, e_os);
      chk("rand_out_pad", out_pad, e_op);
      chk("rand_busy", busy, mp != M_IDLE);
      chk("rand_pad_count", pad_count, m_pads);
      if (!r_in) begin
        for (int i = 0; i < 4; i++) begin
          if (acc[i]) begin
            hold_v[i] = 0;
            gap[i] = ($urandom_range(7) == 0) ? int'($urandom_range(24, 10)) : int'($urandom_range(3));
          end
        end
      end
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
